pp_seq_ctrl: RTL and testbench
==============================

Name: pp_seq_ctrl

Overview:
- Sequencer that drives a programmed stream of {a,b} symbols into the team's two-input pattern FSM, one symbol per cycle.
- Resets the FSM before each run, captures its registered y output, and reports the count of y-high results and the final y value.
- Sits between a host/config interface (memory write port, start/abort) and one pattern-FSM instance.

Parameters:
- DEPTH, 16, number of symbol slots in the pattern memory.
- AW, 4, address width; DEPTH must equal 2**AW.
- CW, 8, width of the ones_cnt result counter.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-low reset.
- wr_en  in  1  pattern-memory write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  2  symbol, {a,b}; bit1 = a, bit0 = b.
- start  in  1  run request, sampled only in IDLE.
- len  in  AW+1  number of symbols to run (1..DEPTH), sampled with start.
- abort  in  1  cancel the current run.
- fsm_rst  out  1  active-high reset to the pattern FSM.
- a_out  out  1  registered a to the FSM.
- b_out  out  1  registered b to the FSM.
- y_in  in  1  registered y from the FSM.
- busy  out  1  high in INIT/RUN/DRAIN.
- done  out  1  one-cycle pulse when a run completes.
- ones_cnt  out  CW  number of y_in-high results in the last run; saturating.
- last_y  out  1  y for the final symbol of the last completed run.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (Rst=0 at an edge):
  - state=IDLE; fsm_rst=1; a_out=b_out=0; busy=done=err=0; ones_cnt=0; last_y=0; idx=0.
  - Pattern memory is not reset.
  - Reset mid-run abandons the run with no done pulse.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE:
  - fsm_rst=0.
  - start=1 with 1<=len<=DEPTH: latch len, go to INIT.
  - start=1 with len=0 or len>DEPTH: err pulse, stay in IDLE.
- INIT (1 cycle):
  - fsm_rst=1, ones_cnt<=0, idx<=1.
  - {a_out,b_out}<=mem[0]; go to RUN.
- RUN (len cycles):
  - fsm_rst=0.
  - Each edge: if idx<len, {a_out,b_out}<=mem[idx] and idx++.
  - From the 2nd RUN cycle on, each edge samples y_in (the result of the previous symbol) and increments ones_cnt if y_in=1.
  - After len cycles go to DRAIN.
- DRAIN (1 cycle):
  - Sample y_in for the last symbol: last_y<=y_in, ones_cnt updated; go to DONE.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- Latency: start accepted at edge E leads to done high in cycle E+len+3. Total busy = len+2 cycles.
- ones_cnt saturates at 2**CW-1 and never wraps. It holds its value until the next INIT.
- a_out/b_out hold their last value after a run; fsm_rst=1 only in INIT or on abort.
- abort=1 in INIT/RUN/DRAIN:
  - Next state is IDLE, with fsm_rst=1 for that one cycle; no done.
  - ones_cnt and last_y hold their partial values.
  - abort in IDLE/DONE is ignored.
- Simultaneous start and abort in IDLE: start wins.
- wr_en while busy: write is dropped and err pulses. wr_en in IDLE/DONE writes.
- wr_en and start in the same IDLE cycle: the write lands before INIT reads mem[0].
- start while busy: ignored, no err.

Decomposition:
- Package pp_pkg:
  - state enum (IDLE, INIT, RUN, DRAIN, DONE);
  - symbol type (2 bits, a/b field positions);
  - default DEPTH/CW constants.
- Sub-module pp_pat_mem: DEPTH x 2 register file, one synchronous write port and one combinational read port. The controller owns the FSM, counters and checks.

Test Plan:
- Write {01,10,01,11} at addresses 0..3, start with len=4, driving the real pattern FSM -> busy for 6 cycles; done in cycle E+7; y sequence 1,1,0,0; ones_cnt=2, last_y=0.
- Write {00,00,00}, len=3 -> y 1,1,1; ones_cnt=3, last_y=1; fsm_rst high exactly once, in the INIT cycle.
- start with len=0, then with len=17 -> err pulse each time, busy stays 0, ones_cnt unchanged.
- Run len=16, abort in the 5th RUN cycle -> next cycle IDLE, fsm_rst=1 for one cycle, no done; then wr_en in IDLE is accepted.
- CW=2 build, all 16 symbols = 00 (y stays 1) -> ones_cnt saturates at 3.
- During a run: wr_en -> err pulse, memory unchanged (readback via a second run); start -> ignored. Rst low mid-RUN -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared types and default sizes for the pattern-sequence controller.
package pp_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;
    localparam int CW_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // One stimulus symbol for the pattern FSM: bit1 = a, bit0 = b.
    typedef struct packed {
        logic a;
        logic b;
    } sym_t;

endpackage

// File: rtl/pp_seq_ctrl_if.sv
// Host/config side plus pattern-FSM side of the sequencer, grouped as one bundle.
interface pp_seq_ctrl_if #(
    parameter int AW = 4,
    parameter int CW = 8
) ();
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    pp_pkg::sym_t  wr_data;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic          fsm_rst;
    logic          a_out;
    logic          b_out;
    logic          y_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] ones_cnt;
    logic          last_y;
    logic          err;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, abort, y_in,
        input  fsm_rst, a_out, b_out, busy, done, ones_cnt, last_y, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, abort, y_in,
        output fsm_rst, a_out, b_out, busy, done, ones_cnt, last_y, err
    );
endinterface

// File: rtl/pp_pat_mem.sv
// Symbol store: DEPTH x 2 register file, synchronous write, combinational read.
module pp_pat_mem
    import pp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          Clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  sym_t          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output sym_t          rdata_o
);
    // Contents are intentionally not reset; the host reprograms them.
    sym_t mem_q [DEPTH];

    // Write port.
    always_ff @(posedge Clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pp_seq_ctrl.sv
// Streams programmed {a,b} symbols into the pattern FSM and tallies its y results.
module pp_seq_ctrl
    import pp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int CW    = CW_DEF
) (
    input logic          Clk,
    input logic          Rst,
    pp_seq_ctrl_if.slave bus
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);

    state_e        state_q;
    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;
    logic [AW:0]   cyc_q;
    logic          fsm_rst_q, a_q, b_q, busy_q, done_q, err_q, last_y_q;
    logic [CW-1:0] ones_q;
    logic          we_s, len_ok_s, idle_s;
    logic [AW-1:0] raddr_s;
    sym_t          rd_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic hit);
        if (hit && (v != CNT_MAX)) begin
            return v + CW'(1);
        end else begin
            return v;
        end
    endfunction

    assign idle_s   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign we_s     = bus.wr_en && idle_s;
    assign len_ok_s = (bus.len != {(AW+1){1'b0}}) && (bus.len <= LEN_MAX);
    // INIT fetches slot 0; RUN fetches the slot the index points at.
    assign raddr_s  = (state_q == ST_RUN) ? idx_q[AW-1:0] : {AW{1'b0}};

    pp_pat_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .Clk     (Clk),
        .we_i    (we_s),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.wr_data),
        .raddr_i (raddr_s),
        .rdata_o (rd_s)
    );

    // Sequencer state machine with registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            fsm_rst_q <= 1'b1;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ones_q    <= {CW{1'b0}};
            last_y_q  <= 1'b0;
            idx_q     <= {(AW+1){1'b0}};
            cyc_q     <= {(AW+1){1'b0}};
            len_q     <= {(AW+1){1'b0}};
        end else begin
            done_q    <= 1'b0;
            err_q     <= bus.wr_en && busy_q;
            fsm_rst_q <= 1'b0;
            if (busy_q && bus.abort) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                fsm_rst_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start && len_ok_s) begin
                            len_q     <= bus.len;
                            state_q   <= ST_INIT;
                            busy_q    <= 1'b1;
                            fsm_rst_q <= 1'b1;
                        end else if (bus.start) begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_INIT: begin
                        ones_q  <= {CW{1'b0}};
                        idx_q   <= ONE;
                        cyc_q   <= ONE;
                        a_q     <= rd_s.a;
                        b_q     <= rd_s.b;
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (idx_q < len_q) begin
                            a_q   <= rd_s.a;
                            b_q   <= rd_s.b;
                            idx_q <= idx_q + ONE;
                        end
                        // The first RUN edge still sees the FSM's post-reset y.
                        if (cyc_q != ONE) begin
                            ones_q <= sat_inc(ones_q, bus.y_in);
                        end
                        if (cyc_q == len_q) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            cyc_q <= cyc_q + ONE;
                        end
                    end
                    ST_DRAIN: begin
                        ones_q   <= sat_inc(ones_q, bus.y_in);
                        last_y_q <= bus.y_in;
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fsm_rst  = fsm_rst_q;
    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ones_cnt = ones_q;
    assign bus.last_y   = last_y_q;
endmodule

// File: tb/tb_pp_seq_ctrl.sv
// Bench for pp_seq_ctrl: run-level reference model, per-cycle comparison, directed runs.
module tb_pp_seq_ctrl;
    import pp_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    pp_seq_ctrl_if #(.AW(4), .CW(8)) ifa ();
    pp_seq_ctrl_if #(.AW(4), .CW(2)) ifs ();

    pp_seq_ctrl #(.DEPTH(16), .AW(4), .CW(8)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
    pp_seq_ctrl #(.DEPTH(16), .AW(4), .CW(2)) dut_s (.Clk(Clk), .Rst(Rst), .bus(ifs));

    // Pattern FSM stand-in: y drops to 0 only when b=1 follows an earlier b=1.
    logic seen_a, y_a, seen_s, y_s;
    always @(posedge Clk) begin
        if (ifa.fsm_rst) begin seen_a <= 1'b0; y_a <= 1'b0; end
        else begin y_a <= ~(ifa.b_out & seen_a); seen_a <= seen_a | ifa.b_out; end
    end
    always @(posedge Clk) begin
        if (ifs.fsm_rst) begin seen_s <= 1'b0; y_s <= 1'b0; end
        else begin y_s <= ~(ifs.b_out & seen_s); seen_s <= seen_s | ifs.b_out; end
    end
    assign ifa.y_in = y_a;
    assign ifs.y_in = y_s;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: a run is a timeline of edges p = 0 .. len+2 after acceptance.
    logic [1:0] m_mem [16];
    bit         m_y [16];
    bit         m_active = 1'b0;
    bit         m_seen;
    int         m_p, m_len;
    logic       e_fsm_rst, e_a, e_b, e_busy, e_done, e_err, e_last_y;
    logic [7:0] e_ones;

    always @(posedge Clk) begin
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!Rst) begin
            m_active = 1'b0;
            e_fsm_rst = 1'b1; e_a = 1'b0; e_b = 1'b0; e_busy = 1'b0;
            e_ones = 8'd0; e_last_y = 1'b0;
        end else if (m_active && m_p <= m_len + 1) begin
            e_fsm_rst = 1'b0;
            if (ifa.wr_en) e_err = 1'b1;
            if (ifa.abort) begin
                m_active = 1'b0; e_busy = 1'b0; e_fsm_rst = 1'b1;
            end else begin
                if (m_p < m_len) {e_a, e_b} = m_mem[m_p];
                if (m_p == 0) e_ones = 8'd0;
                if (m_p >= 2 && m_y[m_p-2] && e_ones != 8'hFF) e_ones = e_ones + 8'd1;
                if (m_p == m_len + 1) begin
                    e_last_y = m_y[m_len-1]; e_busy = 1'b0; e_done = 1'b1;
                end
                m_p = m_p + 1;
            end
        end else begin
            e_fsm_rst = 1'b0;
            if (ifa.wr_en) m_mem[ifa.wr_addr] = ifa.wr_data;
            if (m_active) begin
                m_active = 1'b0;
            end else if (ifa.start) begin
                if (ifa.len >= 5'd1 && ifa.len <= 5'd16) begin
                    m_active = 1'b1; m_p = 0; m_len = int'(ifa.len);
                    m_seen = 1'b0;
                    for (int k = 0; k < m_len; k++) begin
                        m_y[k] = !(m_mem[k][0] && m_seen);
                        m_seen = m_seen | m_mem[k][0];
                    end
                    e_busy = 1'b1; e_fsm_rst = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all controller outputs against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            n_chk = n_chk + 1;
            if ({ifa.fsm_rst, ifa.a_out, ifa.b_out, ifa.busy, ifa.done, ifa.err, ifa.last_y, ifa.ones_cnt}
                !== {e_fsm_rst, e_a, e_b, e_busy, e_done, e_err, e_last_y, e_ones}) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_compare @%0t: dut rst/a/b/busy/done/err/last_y/ones=%b%b%b%b%b%b%b/%0d model=%b%b%b%b%b%b%b/%0d",
                         $time, ifa.fsm_rst, ifa.a_out, ifa.b_out, ifa.busy, ifa.done, ifa.err, ifa.last_y, ifa.ones_cnt,
                         e_fsm_rst, e_a, e_b, e_busy, e_done, e_err, e_last_y, e_ones);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic o_done, o_busy, o_err, o_frst;
    int   hist_busy [0:40];
    int   hist_frst [0:40];

    task automatic step(input logic wr, input logic [3:0] ad, input logic [1:0] dt,
                        input logic st, input logic [4:0] ln, input logic ab);
        @(negedge Clk);
        o_done = ifa.done; o_busy = ifa.busy; o_err = ifa.err; o_frst = ifa.fsm_rst;
        ifa.wr_en = wr; ifa.wr_addr = ad; ifa.wr_data = dt;
        ifa.start = st; ifa.len = ln; ifa.abort = ab;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Steps after an accepted start; inj 1 = write+start mid-run, inj 2 = abort.
    task automatic run_watch(input int maxk, input int inj_k, input int inj,
                             output int done_k, output int busy_n, output int frst_n, output int err_n);
        done_k = -1; busy_n = 0; frst_n = 0; err_n = 0;
        for (int k = 1; k <= maxk; k++) begin
            if (k == inj_k && inj == 1)      step(1'b1, 4'd2, 2'b11, 1'b1, 5'd2, 1'b0);
            else if (k == inj_k && inj == 2) step(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 1'b1);
            else                             idle();
            busy_n += int'(o_busy); frst_n += int'(o_frst); err_n += int'(o_err);
            hist_busy[k] = int'(o_busy); hist_frst[k] = int'(o_frst);
            if (o_done) begin done_k = k; break; end
        end
    endtask

    int dk, bn, fn, en;
    logic [1:0] run1_data [4];

    initial begin
        run1_data[0] = 2'b01; run1_data[1] = 2'b10; run1_data[2] = 2'b01; run1_data[3] = 2'b11;
        ifa.wr_en = 1'b0; ifa.wr_addr = 4'd0; ifa.wr_data = 2'b00; ifa.start = 1'b0; ifa.len = 5'd0; ifa.abort = 1'b0;
        ifs.wr_en = 1'b0; ifs.wr_addr = 4'd0; ifs.wr_data = 2'b00; ifs.start = 1'b0; ifs.len = 5'd0; ifs.abort = 1'b0;
        idle(); chk_en = 1'b1; idle(); idle();
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_fsm_rst", int'(ifa.fsm_rst), 1);
        chk("rst_ones", int'(ifa.ones_cnt), 0);
        Rst = 1'b1;
        idle();

        // Run 1: slot 0 written in the same cycle as start.
        for (int i = 3; i >= 1; i--) step(1'b1, 4'(i), run1_data[i], 1'b0, 5'd0, 1'b0);
        step(1'b1, 4'd0, run1_data[0], 1'b1, 5'd4, 1'b0);
        run_watch(20, 0, 0, dk, bn, fn, en);
        chk("run1_model_y", int'({m_y[0], m_y[1], m_y[2], m_y[3]}), 4'b1100);
        chk("run1_done_cycle", dk, 7);
        chk("run1_busy_cycles", bn, 6);
        chk("run1_ones", int'(ifa.ones_cnt), 2);
        chk("run1_last_y", int'(ifa.last_y), 0);
        idle();

        // Run 2: write and start injected mid-run must be dropped/ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 2'b00, 1'b0, 5'd0, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd3, 1'b0);
        run_watch(20, 2, 1, dk, bn, fn, en);
        chk("run2_done_cycle", dk, 6);
        chk("run2_fsm_rst_once", fn, 1);
        chk("run2_err_pulses", en, 1);
        chk("run2_ones", int'(ifa.ones_cnt), 3);
        chk("run2_last_y", int'(ifa.last_y), 1);
        idle();

        // Readback run: slot 2 must still hold 00.
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd3, 1'b0);
        run_watch(20, 0, 0, dk, bn, fn, en);
        chk("readback_done_cycle", dk, 6);
        chk("readback_ab", int'({ifa.a_out, ifa.b_out}), 0);
        idle();

        // Rejected lengths.
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd0, 1'b0);
        idle();
        chk("len0_err", int'(ifa.err), 1);
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd17, 1'b0);
        idle();
        chk("len17_err", int'(ifa.err), 1);
        chk("len17_busy", int'(ifa.busy), 0);
        chk("len17_ones", int'(ifa.ones_cnt), 3);

        // Abort during the 5th RUN cycle of a 16-symbol run.
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 2'(i), 1'b0, 5'd0, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd16, 1'b0);
        run_watch(12, 6, 2, dk, bn, fn, en);
        chk("abort_no_done", dk, -1);
        chk("abort_busy_cycles", bn, 6);
        chk("abort_busy_after", hist_busy[7], 0);
        chk("abort_fsm_rst_pulse", hist_frst[7], 1);
        chk("abort_fsm_rst_release", hist_frst[8], 0);
        chk("abort_partial_ones", int'(ifa.ones_cnt), 3);
        chk("abort_last_y_hold", int'(ifa.last_y), 1);

        // Write in IDLE after abort, then a one-symbol run.
        step(1'b1, 4'd0, 2'b11, 1'b0, 5'd0, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd1, 1'b0);
        run_watch(20, 0, 0, dk, bn, fn, en);
        chk("len1_done_cycle", dk, 4);
        chk("len1_ab", int'({ifa.a_out, ifa.b_out}), 3);
        chk("len1_ones", int'(ifa.ones_cnt), 1);
        idle();

        // Reset in the middle of RUN.
        step(1'b0, 4'd0, 2'd0, 1'b1, 5'd4, 1'b0);
        idle(); idle(); idle();
        Rst = 1'b0;
        idle();
        chk("midrst_outputs", int'({ifa.fsm_rst, ifa.a_out, ifa.b_out, ifa.busy, ifa.done, ifa.err, ifa.last_y}), 7'b1000000);
        chk("midrst_ones", int'(ifa.ones_cnt), 0);
        Rst = 1'b1;
        idle(); idle();

        // Saturation on the CW=2 instance.
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk); ifs.wr_en = 1'b1; ifs.wr_addr = 4'(i); ifs.wr_data = 2'b00;
        end
        @(negedge Clk); ifs.wr_en = 1'b0; ifs.start = 1'b1; ifs.len = 5'd16;
        @(negedge Clk); ifs.start = 1'b0;
        dk = -1;
        for (int k = 1; k <= 30; k++) begin
            if (ifs.done) begin dk = k; break; end
            @(negedge Clk);
        end
        chk("sat_done_seen", int'(dk > 0), 1);
        chk("sat_ones", int'(ifs.ones_cnt), 3);
        chk("sat_last_y", int'(ifs.last_y), 1);
        idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
